// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared types and counter helpers for the associative BTB
package btb_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam int MAX_CNT_W = 4;
  localparam int MAX_TAG_W = 32;
  localparam int MAX_TGT_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    logic [MAX_CNT_W-1:0] ctr;
    logic [MAX_TGT_W-1:0] target;
  } btb_entry_t;

  function automatic logic [MAX_CNT_W-1:0] ctr_max(input int w);
    return MAX_CNT_W'((1 << w) - 1);
  endfunction

  function automatic logic [MAX_CNT_W-1:0] ctr_inc(input logic [MAX_CNT_W-1:0] c, input int w);
    return (c == ctr_max(w)) ? c : c + 1'b1;
  endfunction

  function automatic logic [MAX_CNT_W-1:0] ctr_dec(input logic [MAX_CNT_W-1:0] c, input int w);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic logic [MAX_CNT_W-1:0] ctr_weak_taken(input int w);
    return MAX_CNT_W'(1 << (w - 1));
  endfunction

endpackage

// File: rtl/btb_assoc_pred_way_select.sv
// rtl/btb_assoc_pred_way_select.sv - tag compare across ways; lowest matching way wins
module btb_way_select #(
  parameter int WAYS  = 2,
  parameter int TAG_W = 22,
  parameter int WAY_W = 1
) (
  input  logic [WAYS-1:0]            valid,
  input  logic [WAYS-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]           tag,
  output logic                       hit,
  output logic [WAY_W-1:0]           hit_way,
  output logic [WAY_W-1:0]           first_invalid,
  output logic                       any_invalid
);

  // Scan high to low so the lowest index overwrites and wins.
  always_comb begin
    hit           = 1'b0;
    hit_way       = '0;
    first_invalid = '0;
    any_invalid   = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[w] && tags[w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid[w]) begin
        any_invalid   = 1'b1;
        first_invalid = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/btb_assoc_pred.sv
// rtl/btb_assoc_pred.sv - N-way set-associative BTB; BTB_ASSOC_STATS_EN adds stat counters
module btb_assoc_pred
  import btb_pkg::*;
#(
  parameter int SETS  = 256,
  parameter int WAYS  = 2,
  parameter int CNT_W = 2,
  parameter int PC_W  = 30,
  parameter int TGT_W = 30
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  input  logic [PC_W-1:0]  lk_pc,
  output logic             lk_hit,
  output logic             lk_taken,
  output logic [TGT_W-1:0] lk_target,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [TGT_W-1:0] upd_target
`ifdef BTB_ASSOC_STATS_EN
  ,
  output logic [31:0]      stat_lookups,
  output logic [31:0]      stat_hits,
  output logic [31:0]      stat_evicts
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = PC_W - IDX_W;

  state_t           state, state_nx;
  logic [IDX_W-1:0] init_ptr;

  btb_entry_t       ent_q [SETS][WAYS];
  logic [WAY_W-1:0] rr_q  [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT) init_ptr <= init_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    if (state == INIT && init_ptr == IDX_W'(SETS - 1)) state_nx = RUN;
  end

  assign ready = (state == RUN);

  logic [IDX_W-1:0]            lk_set, up_set;
  logic [TAG_W-1:0]            lk_tag, up_tag;
  logic [WAYS-1:0]             lk_valid, up_valid;
  logic [WAYS-1:0][TAG_W-1:0]  lk_tags, up_tags;
  logic                        lk_sel_hit, up_hit, up_any_inv;
  logic [WAY_W-1:0]            lk_way, up_way, up_first_inv, victim;
  logic [WAY_W-1:0]            lk_first_inv_unused;
  logic                        lk_any_inv_unused;

  assign lk_set = lk_pc[IDX_W-1:0];
  assign lk_tag = lk_pc[PC_W-1:IDX_W];
  assign up_set = upd_pc[IDX_W-1:0];
  assign up_tag = upd_pc[PC_W-1:IDX_W];

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      lk_valid[w] = ent_q[lk_set][w].valid;
      lk_tags[w]  = ent_q[lk_set][w].tag[TAG_W-1:0];
      up_valid[w] = ent_q[up_set][w].valid;
      up_tags[w]  = ent_q[up_set][w].tag[TAG_W-1:0];
    end
  end

  btb_way_select #(.WAYS(WAYS), .TAG_W(TAG_W), .WAY_W(WAY_W)) u_lk_sel (
    .valid(lk_valid), .tags(lk_tags), .tag(lk_tag),
    .hit(lk_sel_hit), .hit_way(lk_way),
    .first_invalid(lk_first_inv_unused), .any_invalid(lk_any_inv_unused)
  );

  btb_way_select #(.WAYS(WAYS), .TAG_W(TAG_W), .WAY_W(WAY_W)) u_up_sel (
    .valid(up_valid), .tags(up_tags), .tag(up_tag),
    .hit(up_hit), .hit_way(up_way),
    .first_invalid(up_first_inv), .any_invalid(up_any_inv)
  );

  assign lk_hit    = ready & lk_sel_hit;
  assign lk_taken  = lk_hit & ent_q[lk_set][lk_way].ctr[CNT_W-1];
  assign lk_target = lk_hit ? ent_q[lk_set][lk_way].target[TGT_W-1:0] : '0;

  assign victim = up_any_inv ? up_first_inv : rr_q[up_set];

  // Storage has no reset: the INIT sweep invalidates one set per cycle.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      for (int w = 0; w < WAYS; w++) ent_q[init_ptr][w].valid <= 1'b0;
      rr_q[init_ptr] <= '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        ent_q[up_set][up_way].ctr <= upd_taken ? ctr_inc(ent_q[up_set][up_way].ctr, CNT_W)
                                               : ctr_dec(ent_q[up_set][up_way].ctr, CNT_W);
        if (upd_taken) ent_q[up_set][up_way].target <= MAX_TGT_W'(upd_target);
      end else if (upd_taken) begin
        ent_q[up_set][victim].valid  <= 1'b1;
        ent_q[up_set][victim].tag    <= MAX_TAG_W'(up_tag);
        ent_q[up_set][victim].ctr    <= ctr_weak_taken(CNT_W);
        ent_q[up_set][victim].target <= MAX_TGT_W'(upd_target);
        if (!up_any_inv && WAYS > 1)
          rr_q[up_set] <= (rr_q[up_set] == WAY_W'(WAYS - 1)) ? '0 : rr_q[up_set] + 1'b1;
      end
    end
  end

`ifdef BTB_ASSOC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups <= '0;
      stat_hits    <= '0;
      stat_evicts  <= '0;
    end else if (state == RUN && upd_valid) begin
      if (stat_lookups != '1) stat_lookups <= stat_lookups + 1'b1;
      if (up_hit && stat_hits != '1) stat_hits <= stat_hits + 1'b1;
      if (!up_hit && upd_taken && !up_any_inv && stat_evicts != '1)
        stat_evicts <= stat_evicts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_assoc_pred.sv
// tb/tb_btb_assoc_pred.sv - self-checking bench: vector table, random vs model, reset corners
module tb_btb_assoc_pred;

  localparam int SETS = 256, WAYS = 2, CNT_W = 2, PC_W = 30, TGT_W = 30;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             ready;
  logic [PC_W-1:0]  lk_pc;
  logic             lk_hit, lk_taken;
  logic [TGT_W-1:0] lk_target;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic [TGT_W-1:0] upd_target;
`ifdef BTB_ASSOC_STATS_EN
  logic [31:0] stat_lookups, stat_hits, stat_evicts;
`endif

  btb_assoc_pred #(.SETS(SETS), .WAYS(WAYS), .CNT_W(CNT_W), .PC_W(PC_W), .TGT_W(TGT_W)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_target(lk_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
`ifdef BTB_ASSOC_STATS_EN
    , .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_evicts(stat_evicts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: plain per-set arrays of integers.
  bit m_v   [SETS][WAYS];
  int m_tag [SETS][WAYS];
  int m_ctr [SETS][WAYS];
  int m_tgt [SETS][WAYS];
  int m_rr  [SETS];
  bit m_run;
  int m_lk, m_hits, m_ev;

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_v[s][w] = 1'b0;
    end
    m_run = 1'b0;
    m_lk = 0; m_hits = 0; m_ev = 0;
  endfunction

  function automatic int m_find(input int pc);
    int s = pc % SETS;
    int t = pc / SETS;
    for (int w = 0; w < WAYS; w++)
      if (m_v[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  function automatic void m_lookup(input int pc, output bit h, output bit tk, output int tg);
    int w = m_find(pc);
    int s = pc % SETS;
    h = 0; tk = 0; tg = 0;
    if (m_run && w >= 0) begin
      h  = 1;
      tk = (m_ctr[s][w] >= (1 << (CNT_W - 1)));
      tg = m_tgt[s][w];
    end
  endfunction

  function automatic void m_update(input int pc, input bit tk, input int tg);
    int s = pc % SETS;
    int w = m_find(pc);
    if (!m_run) return;
    m_lk++;
    if (w >= 0) begin
      m_hits++;
      m_ctr[s][w] = tk ? ((m_ctr[s][w] + 1 > CMAX) ? CMAX : m_ctr[s][w] + 1)
                       : ((m_ctr[s][w] - 1 < 0) ? 0 : m_ctr[s][w] - 1);
      if (tk) m_tgt[s][w] = tg;
    end else if (tk) begin
      for (int i = WAYS - 1; i >= 0; i--) if (!m_v[s][i]) w = i;
      if (w < 0) begin
        w = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % WAYS;
        m_ev++;
      end
      m_v[s][w]   = 1'b1;
      m_tag[s][w] = pc / SETS;
      m_ctr[s][w] = 1 << (CNT_W - 1);
      m_tgt[s][w] = tg;
    end
  endfunction

  logic s_hit, s_taken;
  logic [TGT_W-1:0] s_tgt;
  bit e_hit, e_taken;
  int e_tgt;

  task automatic cyc(input bit uv, input int upc, input bit ut, input int utg, input int lpc);
    @(negedge clk);
    upd_valid  = uv;
    upd_pc     = PC_W'(upc);
    upd_taken  = ut;
    upd_target = TGT_W'(utg);
    lk_pc      = PC_W'(lpc);
    #1;
    s_hit = lk_hit; s_taken = lk_taken; s_tgt = lk_target;
    m_lookup(lpc, e_hit, e_taken, e_tgt);
    @(posedge clk);
    if (uv) m_update(upc, ut, utg);
  endtask

  // Release rst and follow the sweep; optionally push an update that must be ignored.
  task automatic init_sweep(input string tag, input bit init_upd);
    bit bad = 0;
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    upd_valid = init_upd; upd_pc = PC_W'(32'h505); upd_taken = 1'b1; upd_target = TGT_W'(32'h55);
    lk_pc = PC_W'(32'h105);
    for (int i = 0; i < SETS - 1; i++) begin
      @(posedge clk); #1;
      if (ready !== 1'b0 || lk_hit !== 1'b0) bad = 1;
    end
    chk({tag, "_ready_low_and_miss"}, bad, 0);
    @(posedge clk); #1;
    chk({tag, "_ready_high"}, ready, 1'b1);
    upd_valid = 1'b0;
    m_run = 1'b1;
  endtask

  typedef struct {
    bit uv; int upc; bit ut; int utg; int lpc;
    bit eh; bit et; int etg;
  } vec_t;

  vec_t tbl [19];
  int   live [$];

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1, 'h105, 1, 'h200, 'h105, 0, 0, 0};
    tbl[1]  = '{1, 'h106, 0, 'h999, 'h105, 1, 1, 'h200};
    tbl[2]  = '{1, 'h105, 1, 'h200, 'h106, 0, 0, 0};
    tbl[3]  = '{1, 'h105, 1, 'h200, 'h105, 1, 1, 'h200};
    tbl[4]  = '{1, 'h105, 0, 'h777, 'h105, 1, 1, 'h200};
    tbl[5]  = '{1, 'h105, 0, 'h777, 'h105, 1, 1, 'h200};
    tbl[6]  = '{1, 'h105, 0, 'h777, 'h105, 1, 0, 'h200};
    tbl[7]  = '{1, 'h105, 0, 'h777, 'h105, 1, 0, 'h200};
    tbl[8]  = '{0, 'h000, 0, 'h000, 'h105, 1, 0, 'h200};
    tbl[9]  = '{1, 'h105, 1, 'h300, 'h106, 0, 0, 0};
    tbl[10] = '{0, 'h000, 0, 'h000, 'h105, 1, 0, 'h300};
    tbl[11] = '{1, 'h205, 1, 'h222, 'h205, 0, 0, 0};
    tbl[12] = '{1, 'h305, 1, 'h333, 'h205, 1, 1, 'h222};
    tbl[13] = '{0, 'h000, 0, 'h000, 'h105, 0, 0, 0};
    tbl[14] = '{0, 'h000, 0, 'h000, 'h305, 1, 1, 'h333};
    tbl[15] = '{1, 'h405, 1, 'h444, 'h205, 1, 1, 'h222};
    tbl[16] = '{0, 'h000, 0, 'h000, 'h205, 0, 0, 0};
    tbl[17] = '{0, 'h000, 0, 'h000, 'h405, 1, 1, 'h444};
    tbl[18] = '{0, 'h000, 0, 'h000, 'h305, 1, 1, 'h333};

    rst = 1'b1;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; lk_pc = '0;
    m_clear();
    repeat (3) @(posedge clk);
    #1 chk("reset_ready", ready, 1'b0);
    init_sweep("init", 1'b0);

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].uv, tbl[i].upc, tbl[i].ut, tbl[i].utg, tbl[i].lpc);
      chk($sformatf("vec%0d_hit", i), s_hit, tbl[i].eh);
      chk($sformatf("vec%0d_taken", i), s_taken, tbl[i].et);
      chk($sformatf("vec%0d_target", i), s_tgt, tbl[i].etg);
    end

    for (int i = 0; i < 1500; i++) begin
      int upc, lpc;
      upc = int'($urandom_range(0, 5) << 8) | int'($urandom_range(0, 3));
      lpc = int'($urandom_range(0, 5) << 8) | int'($urandom_range(0, 3));
      cyc($urandom_range(0, 3) != 0, upc, $urandom_range(0, 9) < 7,
          int'($urandom_range(0, 32'h3FFF_FFFF)), lpc);
      chk("rnd_hit", s_hit, e_hit);
      chk("rnd_taken", s_taken, e_taken);
      chk("rnd_target", s_tgt, e_tgt);
    end

`ifdef BTB_ASSOC_STATS_EN
    @(negedge clk);
    chk("stat_lookups", stat_lookups, m_lk);
    chk("stat_hits", stat_hits, m_hits);
    chk("stat_evicts", stat_evicts, m_ev);
`endif

    for (int t = 0; t < 6; t++)
      for (int s = 0; s < 4; s++)
        if (m_find((t << 8) | s) >= 0) live.push_back((t << 8) | s);
    if (m_find('h305) >= 0 || m_find('h405) >= 0) live.push_back('h305);

    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("rst_ready_drop", ready, 1'b0);
    repeat (2) @(posedge clk);
    init_sweep("reinit", 1'b1);

    foreach (live[i]) begin
      cyc(0, 0, 0, 0, live[i]);
      chk($sformatf("post_rst_miss_%0h", live[i]), s_hit, 1'b0);
    end
    cyc(0, 0, 0, 0, 'h505);
    chk("init_update_ignored", s_hit, 1'b0);

`ifdef BTB_ASSOC_STATS_EN
    @(negedge clk);
    chk("stat_lookups_after_rst", stat_lookups, 0);
    force dut.stat_lookups = 32'hFFFF_FFFE;
    #1 release dut.stat_lookups;
    cyc(1, 'h10, 0, 0, 0);
    cyc(1, 'h11, 0, 0, 0);
    @(negedge clk);
    chk("stat_lookups_saturate", stat_lookups, 32'hFFFF_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
